// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_display
// Description : Multiplexed 7-segment display driver. A signed number is
//               accepted over a valid/ready handshake, converted to sign plus
//               BCD digits by a sequential double-dabble, and written into the
//               leftmost FIELD_DIGITS positions (leading-zero blanking and
//               overflow dashes). The remaining positions show caller-supplied
//               raw segment patterns. All digits are scanned round-robin with
//               REFRESH_CYCLES clocks of dwell each.
// Ports       : clk, rst_n     - clock, synchronous active-low reset
//               in_valid/in_ready/in_num - number handshake (two's complement)
//               blank_lz       - blank leading zeros of the magnitude
//               raw_seg        - raw patterns, byte k drives digit FIELD_DIGITS+k
//               busy           - conversion in progress
//               an             - active-low one-hot anodes, an[MSB] = digit 0
//               seg            - active-low segments, bit7=a .. bit1=g, bit0=dp
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int FIELD_DIGITS   = 4,
    parameter int NUM_WIDTH      = 10,
    parameter int REFRESH_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_WIDTH-1:0]  in_num,
    input  logic                  blank_lz,
    // When every digit belongs to the numeric field this collapses to one
    // unused byte so the port never has zero width.
    input  logic [((NUM_DIGITS > FIELD_DIGITS) ? 8*(NUM_DIGITS-FIELD_DIGITS) : 8)-1:0] raw_seg,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);

    localparam int c_MAG_DIGITS = FIELD_DIGITS - 1;
    // Decimal digits needed for 2^NUM_WIDTH; 0.3 underestimates log10(2)
    // without changing the floor for widths up to 16.
    localparam int c_BIN_DIGITS = (NUM_WIDTH * 3) / 10 + 1;
    localparam int c_BCD_DIGITS = (c_BIN_DIGITS > c_MAG_DIGITS) ? c_BIN_DIGITS : c_MAG_DIGITS;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_WORK_W     = c_BCD_W + NUM_WIDTH;
    localparam int c_IDX_W      = $clog2(NUM_DIGITS);
    localparam int c_DWELL_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_CNT_W      = $clog2(NUM_WIDTH + 1);

    localparam logic [7:0] c_SEG_DASH  = 8'b1111_1101;
    localparam logic [7:0] c_SEG_BLANK = 8'b1111_1111;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_SHIFT  = 2'd2;
    localparam logic [1:0] c_ST_COMMIT = 2'd3;

    function automatic logic [7:0] f_digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_digit_seg = 8'b0000_0011;
            4'd1:    f_digit_seg = 8'b1001_1111;
            4'd2:    f_digit_seg = 8'b0010_0101;
            4'd3:    f_digit_seg = 8'b0000_1101;
            4'd4:    f_digit_seg = 8'b1001_1001;
            4'd5:    f_digit_seg = 8'b0100_1001;
            4'd6:    f_digit_seg = 8'b0100_0001;
            4'd7:    f_digit_seg = 8'b0001_1111;
            4'd8:    f_digit_seg = 8'b0000_0001;
            4'd9:    f_digit_seg = 8'b0000_1001;
            default: f_digit_seg = c_SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step on {bcd, binary}: correct nibbles >= 5, shift left.
    function automatic logic [c_WORK_W-1:0] f_dabble(input logic [c_WORK_W-1:0] v);
        logic [c_WORK_W-1:0] t;
        t = v;
        for (int d = 0; d < c_BCD_DIGITS; d++) begin
            if (t[NUM_WIDTH+4*d +: 4] >= 4'd5)
                t[NUM_WIDTH+4*d +: 4] = t[NUM_WIDTH+4*d +: 4] + 4'd3;
        end
        return {t[c_WORK_W-2:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 w_ready;
    logic [NUM_WIDTH-1:0] r_num;
    logic                 r_neg;
    logic [c_WORK_W-1:0]  r_work;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [NUM_WIDTH-1:0] w_mag;
    logic [c_BCD_W-1:0]   w_bcd;
    logic                 w_ovf;
    logic                 w_lead;
    logic [3:0]           w_nib;
    logic [7:0]           r_field      [FIELD_DIGITS];
    logic [7:0]           w_field_next [FIELD_DIGITS];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (in_valid) w_state_next = c_ST_LOAD;
            c_ST_LOAD:   w_state_next = c_ST_SHIFT;
            c_ST_SHIFT:  if (r_cnt == c_CNT_W'(NUM_WIDTH - 1)) w_state_next = c_ST_COMMIT;
            c_ST_COMMIT: w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == c_ST_IDLE);
    end

    assign in_ready = w_ready;
    assign busy     = ~w_ready;

    // Unary minus of the most-negative value yields 2^(NUM_WIDTH-1), which is
    // exactly the magnitude wanted when read as unsigned.
    assign w_mag = r_num[NUM_WIDTH-1] ? -r_num : r_num;
    assign w_bcd = r_work[NUM_WIDTH +: c_BCD_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num  <= '0;
            r_neg  <= 1'b0;
            r_work <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < FIELD_DIGITS; i++) r_field[i] <= c_SEG_BLANK;
        end else begin
            case (r_state)
                c_ST_IDLE: if (in_valid) r_num <= in_num;
                c_ST_LOAD: begin
                    r_neg  <= r_num[NUM_WIDTH-1];
                    r_work <= {{c_BCD_W{1'b0}}, w_mag};
                    r_cnt  <= '0;
                end
                c_ST_SHIFT: begin
                    r_work <= f_dabble(r_work);
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                end
                c_ST_COMMIT: begin
                    for (int i = 0; i < FIELD_DIGITS; i++) r_field[i] <= w_field_next[i];
                end
                default: ;
            endcase
        end
    end

    // Field formatting from the finished BCD. BCD digits at or above
    // c_MAG_DIGITS never reach the display; they only flag overflow.
    always_comb begin
        w_ovf  = 1'b0;
        w_lead = blank_lz;
        w_nib  = 4'd0;
        for (int d = c_MAG_DIGITS; d < c_BCD_DIGITS; d++)
            w_ovf = w_ovf | (w_bcd[4*d +: 4] != 4'd0);
        w_field_next[0] = r_neg ? c_SEG_DASH : c_SEG_BLANK;
        for (int i = 1; i <= c_MAG_DIGITS; i++) begin
            w_nib = w_bcd[4*(c_MAG_DIGITS-i) +: 4];
            // The units digit always shows, so a zero magnitude reads "0".
            if (w_nib != 4'd0 || i == c_MAG_DIGITS) w_lead = 1'b0;
            w_field_next[i] = w_lead ? c_SEG_BLANK : f_digit_seg(w_nib);
        end
        if (w_ovf) begin
            for (int i = 0; i < FIELD_DIGITS; i++) w_field_next[i] = c_SEG_DASH;
        end
    end

    // ------------------------------------------------------------------------
    // Scanner
    // ------------------------------------------------------------------------
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]           r_seg;
    logic [NUM_DIGITS-1:0] w_an;
    logic [7:0]           w_pat;

    always_comb begin
        w_an  = '1;
        w_pat = c_SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_idx == c_IDX_W'(i)) w_an[NUM_DIGITS-1-i] = 1'b0;
        for (int i = 0; i < FIELD_DIGITS; i++)
            if (r_idx == c_IDX_W'(i)) w_pat = r_field[i];
        for (int i = FIELD_DIGITS; i < NUM_DIGITS; i++)
            if (r_idx == c_IDX_W'(i)) w_pat = raw_seg[8*(i-FIELD_DIGITS) +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_dwell <= '0;
            r_an    <= '1;
            r_seg   <= c_SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_pat;
            if (r_dwell == c_DWELL_W'(REFRESH_CYCLES - 1)) begin
                r_dwell <= '0;
                r_idx   <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_dwell <= r_dwell + c_DWELL_W'(1);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule
`default_nettype wire
